// File: rtl/tt_mux_ctrl.sv
// tt_mux_ctrl: upstream control stage for the project multiplexer.
//
// Drives the mux enable, the 5-bit project address and the 18-bit project
// input word. It also registers the 24-bit output word returned by the mux.
// Project selection comes from three asynchronous pins:
//   - sel_rst_n returns the selection to address 0;
//   - each rising edge of sel_inc advances the address;
//   - sel_ena is a level request to enable the selected project.
// Every address change passes through a guard interval with the enable low.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   sel_rst_n         async pin, active low, selection back to address 0
//   sel_inc           async pin, rising edge advances the address
//   sel_ena           async pin, level request to enable the project
//   proj_clk          project clock, passed through combinationally to mux_iw[0]
//   proj_rst_n        async project reset, synchronised and gated to mux_iw[1]
//   ui_in, uio_in     project inputs, passed through to mux_iw[17:2]
//   mux_ena           registered mux enable
//   mux_addr          registered project address
//   mux_iw            project input word {uio_in, ui_in, proj_rst_gated, proj_clk}
//   mux_ow            project output word {uio_oe, uio_out, uo_out}
//   uo_out, uio_out,  registered project outputs, zero outside ACTIVE
//   uio_oe
//   state_o           current FSM state, for debug
module tt_mux_ctrl #(
    parameter int unsigned NUM_PROJECTS = 20,
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel_rst_n,
    input  logic        sel_inc,
    input  logic        sel_ena,
    input  logic        proj_clk,
    input  logic        proj_rst_n,
    input  logic [7:0]  ui_in,
    input  logic [7:0]  uio_in,
    output logic        mux_ena,
    output logic [4:0]  mux_addr,
    output logic [17:0] mux_iw,
    input  logic [23:0] mux_ow,
    output logic [7:0]  uo_out,
    output logic [7:0]  uio_out,
    output logic [7:0]  uio_oe,
    output logic [1:0]  state_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SWITCH = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    localparam logic [4:0] LAST_ADDR  = 5'(NUM_PROJECTS - 1);
    localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES);

    // Synchronisers. All chains clear to 0, so the select reset reads as
    // asserted until the pin has been seen high for SYNC_STAGES edges.
    logic [SYNC_STAGES-1:0] r_sel_rst_sync;
    logic [SYNC_STAGES-1:0] r_sel_inc_sync;
    logic [SYNC_STAGES-1:0] r_sel_ena_sync;
    logic [SYNC_STAGES-1:0] r_proj_rst_sync;
    logic                   r_inc_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_rst_sync  <= '0;
            r_sel_inc_sync  <= '0;
            r_sel_ena_sync  <= '0;
            r_proj_rst_sync <= '0;
            r_inc_prev      <= 1'b0;
        end else begin
            r_sel_rst_sync  <= {r_sel_rst_sync[SYNC_STAGES-2:0], sel_rst_n};
            r_sel_inc_sync  <= {r_sel_inc_sync[SYNC_STAGES-2:0], sel_inc};
            r_sel_ena_sync  <= {r_sel_ena_sync[SYNC_STAGES-2:0], sel_ena};
            r_proj_rst_sync <= {r_proj_rst_sync[SYNC_STAGES-2:0], proj_rst_n};
            r_inc_prev      <= r_sel_inc_sync[SYNC_STAGES-1];
        end
    end

    logic w_sel_rst_n_s;
    logic w_sel_inc_s;
    logic w_sel_ena_s;
    logic w_proj_rst_n_s;
    logic w_inc_evt;

    assign w_sel_rst_n_s  = r_sel_rst_sync[SYNC_STAGES-1];
    assign w_sel_inc_s    = r_sel_inc_sync[SYNC_STAGES-1];
    assign w_sel_ena_s    = r_sel_ena_sync[SYNC_STAGES-1];
    assign w_proj_rst_n_s = r_proj_rst_sync[SYNC_STAGES-1];
    assign w_inc_evt      = w_sel_inc_s & ~r_inc_prev;

    // Selection FSM
    logic [1:0] r_state;
    logic [1:0] w_state_d;
    logic [4:0] r_addr;
    logic [4:0] w_addr_d;
    logic [4:0] w_addr_next;
    logic [7:0] r_guard;
    logic [7:0] w_guard_d;

    assign w_addr_next = (r_addr == LAST_ADDR) ? 5'd0 : r_addr + 5'd1;

    always_comb begin
        w_state_d = r_state;
        w_addr_d  = r_addr;
        w_guard_d = r_guard;
        if (!w_sel_rst_n_s) begin
            // Select reset wins over everything, including a same-cycle increment.
            w_state_d = ST_IDLE;
            w_addr_d  = 5'd0;
            w_guard_d = 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_inc_evt) begin
                        w_addr_d  = w_addr_next;
                        w_state_d = ST_SWITCH;
                        w_guard_d = GUARD_LOAD;
                    end else if (w_sel_ena_s) begin
                        w_state_d = ST_SWITCH;
                        w_guard_d = GUARD_LOAD;
                    end
                end
                ST_SWITCH: begin
                    if (w_inc_evt) begin
                        w_addr_d  = w_addr_next;
                        w_guard_d = GUARD_LOAD;
                    end else if (r_guard <= 8'd1) begin
                        // Last guard cycle; a zero count also counts as expired.
                        w_state_d = w_sel_ena_s ? ST_ACTIVE : ST_IDLE;
                        w_guard_d = 8'd0;
                    end else begin
                        w_guard_d = r_guard - 8'd1;
                    end
                end
                ST_ACTIVE: begin
                    if (w_inc_evt) begin
                        w_addr_d  = w_addr_next;
                        w_state_d = ST_SWITCH;
                        w_guard_d = GUARD_LOAD;
                    end else if (!w_sel_ena_s) begin
                        w_state_d = ST_IDLE;
                    end
                end
                default: begin
                    w_state_d = ST_IDLE;
                    w_guard_d = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= 5'd0;
            r_guard <= 8'd0;
        end else begin
            r_state <= w_state_d;
            r_addr  <= w_addr_d;
            r_guard <= w_guard_d;
        end
    end

    // The enable and output registers are loaded only when the FSM is in
    // ACTIVE and stays there. They therefore rise one cycle after ACTIVE
    // is entered, and drop on the same edge that leaves it.
    logic w_stay_active;
    assign w_stay_active = (r_state == ST_ACTIVE) && (w_state_d == ST_ACTIVE);

    logic        r_mux_ena;
    logic [23:0] r_ow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mux_ena <= 1'b0;
            r_ow      <= 24'h0;
        end else begin
            r_mux_ena <= w_stay_active;
            r_ow      <= w_stay_active ? mux_ow : 24'h0;
        end
    end

    // Hold the project in reset unless it is the active one.
    logic w_proj_rst_gated;
    assign w_proj_rst_gated = w_proj_rst_n_s & (r_state == ST_ACTIVE);

    assign mux_ena  = r_mux_ena;
    assign mux_addr = r_addr;
    assign mux_iw   = {uio_in, ui_in, w_proj_rst_gated, proj_clk};
    assign uo_out   = r_ow[7:0];
    assign uio_out  = r_ow[15:8];
    assign uio_oe   = r_ow[23:16];
    assign state_o  = r_state;

endmodule
